hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central hazard and stall controller for the 5-stage pipeline.
- Consumes the register-read fields of ID and the load, write-back and redirect fields of EX, plus the MEM-stage data-memory handshake.
- Drives the stall/flush inputs of PC, IF_ID, ID_EX, EX_MEM and MEM_WB, inserting bubbles and squashing wrong-path instructions.
- Tracks multi-cycle memory waits with an FSM, flags wait timeouts, and keeps stall/flush performance counters.

Parameters:
- WAIT_MAX, 16, max consecutive memory-wait cycles before err_timeout is set (>=2).
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ID_rs  in  5  rs field of instruction in ID
- ID_rt  in  5  rt field of instruction in ID
- ID_regread1  in  1  ID instruction reads rs
- ID_regread2  in  1  ID instruction reads rt
- EX_memread  in  1  EX instruction is a load
- EX_regwrite  in  1  EX instruction writes a register
- EX_wraddr  in  5  EX destination register
- EX_redirect  in  1  EX resolved taken branch / jump / jr (next PC differs from pc+4)
- MEM_req  in  1  MEM stage data-memory access active
- MEM_ready  in  1  data memory completes access this cycle
- pc_stall  out  1  hold PC
- IF_ID_stall  out  1  hold IF_ID
- IF_ID_flush  out  1  load NOP into IF_ID
- ID_EX_stall  out  1  hold ID_EX
- ID_EX_flush  out  1  load NOP into ID_EX
- EX_MEM_stall  out  1  hold EX_MEM
- MEM_WB_flush  out  1  load bubble into MEM_WB
- err_timeout  out  1  sticky: a memory wait exceeded WAIT_MAX
- stall_cnt  out  CNT_W  cycles with pc_stall=1, saturating
- flush_cnt  out  CNT_W  redirect events applied, saturating

Behaviour:
- Reset: FSM=RUN, wait_cnt=0, err_timeout=0, stall_cnt=0, flush_cnt=0. While rst=1, all stall outputs are 0 and all flush outputs are 1.
- Term definitions (combinational, same cycle):
  - mem_stall = MEM_req & !MEM_ready.
  - load_use = EX_memread & EX_regwrite & (EX_wraddr!=0) & ((ID_regread1 & ID_rs==EX_wraddr) | (ID_regread2 & ID_rt==EX_wraddr)).
- Priority, highest first:
  - mem_stall: pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall =1; MEM_WB_flush=1; all other flushes 0. A redirect or load-use present in the same cycle is held, not applied; frozen EX keeps its inputs valid for the cycle after the wait ends.
  - EX_redirect: IF_ID_flush=1, ID_EX_flush=1, no stalls; PC takes the redirect target. load_use is ignored because the ID instruction is squashed.
  - load_use: pc_stall=1, IF_ID_stall=1, ID_EX_flush=1 (one bubble). This lasts exactly one cycle: next cycle the load is in MEM, EX_memread for the bubble is 0, and forwarding covers the rest.
  - none: all outputs 0.
- FSM, states RUN and WAIT:
  - RUN -> WAIT when mem_stall; wait_cnt <= 1.
  - WAIT stays while mem_stall; wait_cnt increments, saturating at WAIT_MAX.
  - WAIT -> RUN when MEM_ready or !MEM_req; wait_cnt <= 0.
  - While in WAIT with mem_stall and wait_cnt==WAIT_MAX, err_timeout <= 1 (sticky until rst). Stalling continues regardless; the timeout never unfreezes the pipe.
  - A 1-cycle access (MEM_ready with MEM_req in RUN) causes no stall and no state change.
- Counters:
  - stall_cnt += 1 on each clock edge where pc_stall=1 (mem_stall or load_use).
  - flush_cnt += 1 on each edge where EX_redirect is applied (not masked by mem_stall).
  - Both saturate at all-ones and never wrap.
- Reset asserted mid-wait: immediate return to RUN, counters cleared, outputs at reset values.
- Register 0 never causes load_use.

Test Plan:
- Load-use: EX lw to r5 (memread=1, regwrite=1, wraddr=5), ID reads rs=5 -> one cycle of pc_stall=1, IF_ID_stall=1, ID_EX_flush=1; stall_cnt=1. Same case with wraddr=0 -> no stall.
- Redirect: EX_redirect=1 with simultaneous load_use -> IF_ID_flush=ID_EX_flush=1, pc_stall=0, flush_cnt=1.
- Memory wait: MEM_req=1, MEM_ready low 3 cycles then high -> 3 cycles of all four stalls plus MEM_WB_flush; FSM RUN->WAIT->RUN; stall_cnt=3; err_timeout=0.
- Wait with pending redirect: EX_redirect=1 during a 2-cycle mem wait -> no flushes during the wait, flushes in the cycle after MEM_ready; flush_cnt=1.
- Timeout: MEM_ready held low for WAIT_MAX+2 cycles -> err_timeout rises after WAIT_MAX cycles, stalls persist, MEM_ready then releases the pipe, err_timeout stays 1.
- Reset mid-wait: assert rst during WAIT -> all stalls 0, flushes 1, counters 0, err_timeout 0, FSM RUN after release.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle: ID/EX hazard fields, MEM handshake,
// and the stall/flush/status outputs that steer the pipeline registers.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ID_rs;
  logic [4:0]       ID_rt;
  logic             ID_regread1;
  logic             ID_regread2;
  logic             EX_memread;
  logic             EX_regwrite;
  logic [4:0]       EX_wraddr;
  logic             EX_redirect;
  logic             MEM_req;
  logic             MEM_ready;
  logic             pc_stall;
  logic             IF_ID_stall;
  logic             IF_ID_flush;
  logic             ID_EX_stall;
  logic             ID_EX_flush;
  logic             EX_MEM_stall;
  logic             MEM_WB_flush;
  logic             err_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ID_rs, ID_rt, ID_regread1, ID_regread2,
           EX_memread, EX_regwrite, EX_wraddr, EX_redirect,
           MEM_req, MEM_ready,
    input  pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
           EX_MEM_stall, MEM_WB_flush, err_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  ID_rs, ID_rt, ID_regread1, ID_regread2,
           EX_memread, EX_regwrite, EX_wraddr, EX_redirect,
           MEM_req, MEM_ready,
    output pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
           EX_MEM_stall, MEM_WB_flush, err_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: memory-wait freeze, redirect
// squash, load-use bubble, wait-timeout flag and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);
  localparam int WC_W = $clog2(WAIT_MAX + 1);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t           r_state, w_state_nxt;
  logic [WC_W-1:0]  r_wait_cnt, w_wait_nxt;
  logic             r_err, w_err_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic w_mem_stall, w_load_use, w_redirect_apply, w_pc_stall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_mem_stall = hz.MEM_req & ~hz.MEM_ready;
  assign w_load_use  = hz.EX_memread & hz.EX_regwrite & (hz.EX_wraddr != 5'd0) &
                       ((hz.ID_regread1 & (hz.ID_rs == hz.EX_wraddr)) |
                        (hz.ID_regread2 & (hz.ID_rt == hz.EX_wraddr)));
  // A memory wait masks both redirect and load-use; the frozen EX re-presents them later.
  assign w_redirect_apply = hz.EX_redirect & ~w_mem_stall;
  assign w_pc_stall       = w_mem_stall | (w_load_use & ~hz.EX_redirect);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_err      <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_err_nxt   = r_err;
    case (r_state)
      ST_RUN: begin
        if (w_mem_stall) begin
          w_state_nxt = ST_WAIT;
          w_wait_nxt  = WC_W'(1);
        end
      end
      ST_WAIT: begin
        if (w_mem_stall) begin
          if (r_wait_cnt == WC_W'(WAIT_MAX)) w_err_nxt = 1'b1;
          else                               w_wait_nxt = r_wait_cnt + WC_W'(1);
        end else begin
          w_state_nxt = ST_RUN;
          w_wait_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_wait_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_pc_stall)       r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_redirect_apply) r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  // Reset forces every pipeline register to a NOP; otherwise priority is wait > redirect > load-use.
  always_comb begin
    hz.pc_stall     = 1'b0;
    hz.IF_ID_stall  = 1'b0;
    hz.IF_ID_flush  = 1'b0;
    hz.ID_EX_stall  = 1'b0;
    hz.ID_EX_flush  = 1'b0;
    hz.EX_MEM_stall = 1'b0;
    hz.MEM_WB_flush = 1'b0;
    if (rst) begin
      hz.IF_ID_flush  = 1'b1;
      hz.ID_EX_flush  = 1'b1;
      hz.MEM_WB_flush = 1'b1;
    end else if (w_mem_stall) begin
      hz.pc_stall     = 1'b1;
      hz.IF_ID_stall  = 1'b1;
      hz.ID_EX_stall  = 1'b1;
      hz.EX_MEM_stall = 1'b1;
      hz.MEM_WB_flush = 1'b1;
    end else if (hz.EX_redirect) begin
      hz.IF_ID_flush  = 1'b1;
      hz.ID_EX_flush  = 1'b1;
    end else if (w_load_use) begin
      hz.pc_stall     = 1'b1;
      hz.IF_ID_stall  = 1'b1;
      hz.ID_EX_flush  = 1'b1;
    end
  end

  assign hz.err_timeout = r_err;
  assign hz.stall_cnt   = r_stall_cnt;
  assign hz.flush_cnt   = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset, load-use, redirect, memory waits, timeout,
// reset during a wait and counter saturation, with hand-computed expectations.
module tb_hazard_ctrl;
  localparam int WAIT_MAX = 4;
  localparam int CNT_W    = 4;

  // Output vector order: pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_flush
  localparam logic [6:0] O_NONE  = 7'b000_0000;
  localparam logic [6:0] O_RST   = 7'b001_0101;
  localparam logic [6:0] O_MEM   = 7'b110_1011;
  localparam logic [6:0] O_REDIR = 7'b001_0100;
  localparam logic [6:0] O_LU    = 7'b110_0100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  always #5 clk = ~clk;

  logic [6:0] outs;
  assign outs = {hz.pc_stall, hz.IF_ID_stall, hz.IF_ID_flush, hz.ID_EX_stall,
                 hz.ID_EX_flush, hz.EX_MEM_stall, hz.MEM_WB_flush};

  task automatic idle();
    hz.ID_rs = 5'd0; hz.ID_rt = 5'd0; hz.ID_regread1 = 1'b0; hz.ID_regread2 = 1'b0;
    hz.EX_memread = 1'b0; hz.EX_regwrite = 1'b0; hz.EX_wraddr = 5'd0; hz.EX_redirect = 1'b0;
    hz.MEM_req = 1'b0; hz.MEM_ready = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use(input logic [4:0] wa, input logic [4:0] rs, input logic [4:0] rt,
                              input logic rd1, input logic rd2);
    hz.EX_memread = 1'b1; hz.EX_regwrite = 1'b1; hz.EX_wraddr = wa;
    hz.ID_rs = rs; hz.ID_rt = rt; hz.ID_regread1 = rd1; hz.ID_regread2 = rd2;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle();
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset();
    idle();
    hz.MEM_req = 1'b1;
    next_cycle();
    @(negedge clk);
    total++; if (outs !== O_RST) begin bad++; $display("FAIL reset_outs got=%b exp=%b", outs, O_RST); end
    total++; if (hz.stall_cnt !== 4'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", hz.stall_cnt); end
    total++; if (hz.flush_cnt !== 4'd0) begin bad++; $display("FAIL reset_flush_cnt got=%0d exp=0", hz.flush_cnt); end
    total++; if (hz.err_timeout !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", hz.err_timeout); end
    next_cycle();
    rst = 1'b0;
    idle();
    @(negedge clk);
    total++; if (outs !== O_NONE) begin bad++; $display("FAIL post_reset_outs got=%b exp=%b", outs, O_NONE); end
    next_cycle();
  endtask

  task automatic test_load_use();
    apply_reset();
    set_load_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    total++; if (outs !== O_LU) begin bad++; $display("FAIL lu_rs_outs got=%b exp=%b", outs, O_LU); end
    next_cycle();
    idle();
    @(negedge clk);
    total++; if (outs !== O_NONE) begin bad++; $display("FAIL lu_one_cycle got=%b exp=%b", outs, O_NONE); end
    total++; if (hz.stall_cnt !== 4'd1) begin bad++; $display("FAIL lu_stall_cnt got=%0d exp=1", hz.stall_cnt); end
    next_cycle();
    set_load_use(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    @(negedge clk);
    total++; if (outs !== O_NONE) begin bad++; $display("FAIL lu_r0 got=%b exp=%b", outs, O_NONE); end
    next_cycle();
    set_load_use(5'd7, 5'd3, 5'd7, 1'b1, 1'b1);
    @(negedge clk);
    total++; if (outs !== O_LU) begin bad++; $display("FAIL lu_rt got=%b exp=%b", outs, O_LU); end
    next_cycle();
    set_load_use(5'd7, 5'd3, 5'd7, 1'b1, 1'b0);
    @(negedge clk);
    total++; if (outs !== O_NONE) begin bad++; $display("FAIL lu_rt_noread got=%b exp=%b", outs, O_NONE); end
    next_cycle();
    set_load_use(5'd9, 5'd9, 5'd0, 1'b1, 1'b0);
    hz.EX_memread = 1'b0;
    @(negedge clk);
    total++; if (outs !== O_NONE) begin bad++; $display("FAIL lu_not_load got=%b exp=%b", outs, O_NONE); end
    next_cycle();
    idle();
    @(negedge clk);
    total++; if (hz.stall_cnt !== 4'd2) begin bad++; $display("FAIL lu_stall_cnt2 got=%0d exp=2", hz.stall_cnt); end
  endtask

  task automatic test_redirect();
    apply_reset();
    set_load_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    hz.EX_redirect = 1'b1;
    @(negedge clk);
    total++; if (outs !== O_REDIR) begin bad++; $display("FAIL redir_outs got=%b exp=%b", outs, O_REDIR); end
    next_cycle();
    idle();
    @(negedge clk);
    total++; if (hz.flush_cnt !== 4'd1) begin bad++; $display("FAIL redir_flush_cnt got=%0d exp=1", hz.flush_cnt); end
    total++; if (hz.stall_cnt !== 4'd0) begin bad++; $display("FAIL redir_stall_cnt got=%0d exp=0", hz.stall_cnt); end
  endtask

  task automatic test_mem_wait();
    apply_reset();
    hz.MEM_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (outs !== O_MEM) begin bad++; $display("FAIL memwait_outs cyc=%0d got=%b exp=%b", k, outs, O_MEM); end
      next_cycle();
    end
    hz.MEM_ready = 1'b1;
    @(negedge clk);
    total++; if (outs !== O_NONE) begin bad++; $display("FAIL memwait_release got=%b exp=%b", outs, O_NONE); end
    next_cycle();
    @(negedge clk);
    total++; if (outs !== O_NONE) begin bad++; $display("FAIL one_cycle_access got=%b exp=%b", outs, O_NONE); end
    total++; if (hz.stall_cnt !== 4'd3) begin bad++; $display("FAIL memwait_stall_cnt got=%0d exp=3", hz.stall_cnt); end
    total++; if (hz.err_timeout !== 1'b0) begin bad++; $display("FAIL memwait_err got=%b exp=0", hz.err_timeout); end
    next_cycle();
    idle();
  endtask

  task automatic test_wait_redirect();
    apply_reset();
    hz.MEM_req = 1'b1;
    hz.EX_redirect = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++; if (outs !== O_MEM) begin bad++; $display("FAIL wr_held cyc=%0d got=%b exp=%b", k, outs, O_MEM); end
      next_cycle();
    end
    total++; if (hz.flush_cnt !== 4'd0) begin bad++; $display("FAIL wr_flush_cnt_held got=%0d exp=0", hz.flush_cnt); end
    hz.MEM_ready = 1'b1;
    @(negedge clk);
    total++; if (outs !== O_REDIR) begin bad++; $display("FAIL wr_applied got=%b exp=%b", outs, O_REDIR); end
    next_cycle();
    idle();
    @(negedge clk);
    total++; if (hz.flush_cnt !== 4'd1) begin bad++; $display("FAIL wr_flush_cnt got=%0d exp=1", hz.flush_cnt); end
    total++; if (hz.stall_cnt !== 4'd2) begin bad++; $display("FAIL wr_stall_cnt got=%0d exp=2", hz.stall_cnt); end
  endtask

  task automatic test_timeout();
    logic exp_err;
    apply_reset();
    hz.MEM_req = 1'b1;
    for (int k = 1; k <= WAIT_MAX + 2; k++) begin
      exp_err = (k >= WAIT_MAX + 2);
      @(negedge clk);
      total++; if (hz.err_timeout !== exp_err) begin bad++; $display("FAIL to_err cyc=%0d got=%b exp=%b", k, hz.err_timeout, exp_err); end
      total++; if (outs !== O_MEM) begin bad++; $display("FAIL to_stall cyc=%0d got=%b exp=%b", k, outs, O_MEM); end
      next_cycle();
    end
    hz.MEM_ready = 1'b1;
    @(negedge clk);
    total++; if (outs !== O_NONE) begin bad++; $display("FAIL to_release got=%b exp=%b", outs, O_NONE); end
    next_cycle();
    idle();
    @(negedge clk);
    total++; if (hz.err_timeout !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", hz.err_timeout); end
    total++; if (hz.stall_cnt !== 4'd6) begin bad++; $display("FAIL to_stall_cnt got=%0d exp=6", hz.stall_cnt); end
    next_cycle();
  endtask

  // Runs straight after the timeout test so err_timeout is 1 going in.
  task automatic test_reset_mid_wait();
    hz.MEM_req = 1'b1;
    hz.EX_redirect = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    #1;
    total++; if (outs !== O_RST) begin bad++; $display("FAIL rmw_outs got=%b exp=%b", outs, O_RST); end
    total++; if (hz.stall_cnt !== 4'd0) begin bad++; $display("FAIL rmw_stall_cnt got=%0d exp=0", hz.stall_cnt); end
    total++; if (hz.flush_cnt !== 4'd0) begin bad++; $display("FAIL rmw_flush_cnt got=%0d exp=0", hz.flush_cnt); end
    total++; if (hz.err_timeout !== 1'b0) begin bad++; $display("FAIL rmw_err got=%b exp=0", hz.err_timeout); end
    next_cycle();
    rst = 1'b0;
    idle();
    @(negedge clk);
    total++; if (outs !== O_NONE) begin bad++; $display("FAIL rmw_after got=%b exp=%b", outs, O_NONE); end
    next_cycle();
    // A fresh wait of exactly WAIT_MAX cycles must not trip the timeout if the FSM restarted in RUN.
    hz.MEM_req = 1'b1;
    for (int k = 0; k < WAIT_MAX; k++) next_cycle();
    hz.MEM_ready = 1'b1;
    next_cycle();
    idle();
    @(negedge clk);
    total++; if (hz.err_timeout !== 1'b0) begin bad++; $display("FAIL rmw_fresh_err got=%b exp=0", hz.err_timeout); end
    total++; if (hz.stall_cnt !== 4'd4) begin bad++; $display("FAIL rmw_stall_cnt2 got=%0d exp=4", hz.stall_cnt); end
  endtask

  task automatic test_saturate();
    apply_reset();
    set_load_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) next_cycle();
    idle();
    hz.EX_redirect = 1'b1;
    for (int k = 0; k < 20; k++) next_cycle();
    idle();
    @(negedge clk);
    total++; if (hz.stall_cnt !== 4'hF) begin bad++; $display("FAIL sat_stall_cnt got=%0d exp=15", hz.stall_cnt); end
    total++; if (hz.flush_cnt !== 4'hF) begin bad++; $display("FAIL sat_flush_cnt got=%0d exp=15", hz.flush_cnt); end
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_wait_redirect();
    test_timeout();
    test_reset_mid_wait();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
